// File: rtl/pa_risc_program_loader_pkg.sv
// Shared definitions for the PA-RISC program loader: FSM encodings and frame layout.
package pa_risc_program_loader_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CHK    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam int unsigned LenBytes  = 2;
  localparam int unsigned WordBytes = 4;
  localparam int unsigned ChkBytes  = 1;

  localparam logic [1:0] LastByteIdx = 2'(WordBytes - 1);

endpackage

// File: rtl/pa_risc_word_packer.sv
// Packs accepted stream bytes MSB-first into 32-bit words with a one-cycle word_valid pulse.
module pa_risc_word_packer
  import pa_risc_program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] hold_q, hold_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  assign last_byte_o  = (cnt_q == LastByteIdx);
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

  always_comb begin
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      hold_d = {hold_q[15:0], byte_i};
      if (cnt_q == LastByteIdx) begin
        word_d  = {hold_q, byte_i};
        valid_d = 1'b1;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/pa_risc_program_loader.sv
// Streams a length/data/checksum frame into instruction memory and releases the core on success.
module pa_risc_program_loader
  import pa_risc_program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_written
);

  localparam int unsigned MEM_WORDS = (2 ** ADDR_W) / WordBytes;
  localparam int unsigned IdxW      = ADDR_W - 2;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [IdxW-1:0]   widx_q, widx_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic        accept, restart, data_acc, last_byte;
  logic [15:0] len_full;

  assign in_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DATA) || (state_q == CHK);
  assign accept   = in_valid & in_ready;
  assign restart  = start & ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign data_acc = accept & (state_q == DATA);
  assign len_full = {len_q[15:8], in_data};

  pa_risc_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (restart),
    .byte_valid_i (data_acc),
    .byte_i       (in_data),
    .last_byte_o  (last_byte),
    .word_o       (mem_wdata),
    .word_valid_o (mem_we)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    wcnt_d  = wcnt_q;
    xor_d   = xor_q;
    addr_d  = addr_q;
    if (restart) begin
      state_d = LEN_HI;
      widx_d  = '0;
      wcnt_d  = '0;
      xor_d   = '0;
    end else if (accept) begin
      if (state_q != CHK) xor_d = xor_q ^ in_data;
      case (state_q)
        LEN_HI: begin
          len_d[15:8] = in_data;
          state_d     = LEN_LO;
        end
        LEN_LO: begin
          len_d[7:0] = in_data;
          if (len_full > 16'(MEM_WORDS)) state_d = ERR;
          else if (len_full == 16'd0)    state_d = CHK;
          else                           state_d = DATA;
        end
        DATA: begin
          // Address is captured alongside the word so both appear with the write pulse.
          if (last_byte) begin
            addr_d = {widx_q, 2'b00};
            widx_d = widx_q + 1'b1;
            wcnt_d = wcnt_q + 16'd1;
            if (wcnt_q + 16'd1 == len_q) state_d = CHK;
          end
        end
        CHK:     state_d = (in_data == xor_q) ? DONE : ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      wcnt_q  <= '0;
      xor_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      wcnt_q  <= wcnt_d;
      xor_q   <= xor_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_addr      = addr_q;
  assign busy          = in_ready;
  assign done          = (state_q == DONE);
  assign error         = (state_q == ERR);
  assign cpu_reset     = (state_q != DONE);
  assign words_written = wcnt_q;

endmodule

// File: tb/tb_pa_risc_program_loader.sv
// Scoreboarded bench: expected memory writes are queued by the stimulus and popped by a monitor.
module tb_pa_risc_program_loader;

  localparam int unsigned ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, cpu_reset, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [15:0]       words_written;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+31:0] exp_q[$];

  pa_risc_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_reset     (cpu_reset),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // Write monitor: every mem_we pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      logic [ADDR_W+31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr %h data %h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr %h data %h, required addr %h data %h",
                   mem_addr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic push_nominal();
    exp_q.push_back({9'h000, 32'h08221601});
    exp_q.push_back({9'h004, 32'h3401000B});
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] nom[$];
  logic [7:0] bad[$];
  logic [7:0] bytes[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    nom = '{8'h00, 8'h02, 8'h08, 8'h22, 8'h16, 8'h01, 8'h34, 8'h01, 8'h00, 8'h0B, 8'h01};
    bad = '{8'h00, 8'h02, 8'h08, 8'h22, 8'h16, 8'h01, 8'h34, 8'h01, 8'h00, 8'h0B, 8'h00};
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #23;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Nominal load
    pulse_start();
    chk("nom_busy", 32'(busy), 32'd1);
    push_nominal();
    send_bytes(nom, 0);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("nom_error", 32'(error), 32'd0);
    chk("nom_busy_end", 32'(busy), 32'd0);
    chk("nom_words", 32'(words_written), 32'd2);
    drain("nom_sb_empty");
    chk("nom_done_hold", 32'(done), 32'd1);

    // Bad checksum; restart from DONE clears status
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("restart_words", 32'(words_written), 32'd0);
    push_nominal();
    send_bytes(bad, 0);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("bad_words", 32'(words_written), 32'd2);
    drain("bad_sb_empty");

    // Oversize: N = 129
    pulse_start();
    chk("over_error_cleared", 32'(error), 32'd0);
    bytes = '{8'h00, 8'h81};
    send_bytes(bytes, 0);
    chk("over_error", 32'(error), 32'd1);
    chk("over_in_ready", 32'(in_ready), 32'd0);
    chk("over_busy", 32'(busy), 32'd0);
    drain("over_sb_empty");
    chk("over_words", 32'(words_written), 32'd0);

    // Zero-length load
    pulse_start();
    bytes = '{8'h00, 8'h00, 8'h00};
    send_bytes(bytes, 0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_words", 32'(words_written), 32'd0);
    drain("zero_sb_empty");

    // Throttled input with an ignored start mid-DATA
    pulse_start();
    push_nominal();
    bytes = nom[0:3];
    send_bytes(bytes, 1);
    pulse_start();
    chk("thr_busy_after_start", 32'(busy), 32'd1);
    bytes = nom[4:10];
    send_bytes(bytes, 1);
    chk("thr_done", 32'(done), 32'd1);
    chk("thr_words", 32'(words_written), 32'd2);
    drain("thr_sb_empty");

    // Reset mid-DATA after 6 bytes drops the pending write
    pulse_start();
    bytes = nom[0:5];
    send_bytes(bytes, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_words", 32'(words_written), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    pulse_start();
    push_nominal();
    send_bytes(nom, 0);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_words", 32'(words_written), 32'd2);
    drain("post_rst_sb_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
